// File: rtl/sklansky_sub8_pipe_if.sv
// Handshake and operand/result bundle for the pipelined Sklansky subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface sklansky_sub8_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf, zero
    );
endinterface

// File: rtl/sklansky_sub8_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin, computed as a + ~b + ~bin on a
// Sklansky prefix network; stage 1 registers the prefix, stage 2 the sum and flags.
module sklansky_sub8_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sklansky_sub8_pipe_if.slave  bus
);
    localparam int LOG = $clog2(WIDTH);

    // Position of the last bit in the lower half of the aligned 2^(k+1) block holding j.
    function automatic int blk_tail(input int j, input int k);
        return ((j >> (k + 32'sd1)) << (k + 32'sd1)) + (32'sd1 << k) - 32'sd1;
    endfunction

    logic [WIDTH-1:0] lvl_g_s [0:LOG];
    logic [WIDTH-1:0] lvl_p_s [0:LOG];
    logic             cin_s;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             in_take_s;
    logic             s1_move_s;

    logic             s1_valid_q;
    logic [WIDTH:0]   g1_q;
    logic [WIDTH-1:0] p1_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH:0]   g1_d;

    logic             s2_valid_q;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             ovf_q;
    logic             zero_q;
    logic [WIDTH-1:0] d_d;
    logic             bout_d;
    logic             ovf_d;
    logic             zero_d;

    // Carry-in is folded into bit 0's generate so the tree itself stays log2(WIDTH) deep.
    always_comb begin
        cin_s         = ~bus.bin;
        lvl_p_s[0]    = bus.a ^ ~bus.b;
        lvl_g_s[0]    = bus.a & ~bus.b;
        lvl_g_s[0][0] = lvl_g_s[0][0] | (lvl_p_s[0][0] & cin_s);
        for (int k = 0; k < LOG; k++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if (j[k]) begin
                    lvl_g_s[k+1][j] = lvl_g_s[k][j] | (lvl_p_s[k][j] & lvl_g_s[k][blk_tail(j, k)]);
                    lvl_p_s[k+1][j] = lvl_p_s[k][j] & lvl_p_s[k][blk_tail(j, k)];
                end else begin
                    lvl_g_s[k+1][j] = lvl_g_s[k][j];
                    lvl_p_s[k+1][j] = lvl_p_s[k][j];
                end
            end
        end
    end

    // Flow control and next-state values for both stages.
    always_comb begin
        s2_adv_s  = ~s2_valid_q | bus.out_ready;
        s1_adv_s  = ~s1_valid_q | s2_adv_s;
        in_take_s = bus.in_valid & s1_adv_s;
        s1_move_s = s1_valid_q & s2_adv_s;
        g1_d      = {lvl_g_s[LOG], cin_s};
        d_d       = p1_q ^ g1_q[WIDTH-1:0];
        bout_d    = ~g1_q[WIDTH];
        ovf_d     = (a_msb_q != b_msb_q) & (d_d[WIDTH-1] != a_msb_q);
        zero_d    = ~|d_d;
    end

    // Pipeline registers; operand data loads only on a real handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            g1_q       <= {(WIDTH+1){1'b0}};
            p1_q       <= {WIDTH{1'b0}};
            a_msb_q    <= 1'b0;
            b_msb_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            d_q        <= {WIDTH{1'b0}};
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_q <= bus.in_valid;
            end
            if (in_take_s) begin
                g1_q    <= g1_d;
                p1_q    <= lvl_p_s[0];
                a_msb_q <= bus.a[WIDTH-1];
                b_msb_q <= bus.b[WIDTH-1];
            end
            if (s2_adv_s) begin
                s2_valid_q <= s1_valid_q;
            end
            if (s1_move_s) begin
                d_q    <= d_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule
